piso_stream: RTL and testbench
==============================

// Module: piso_stream
// PURPOSE
//   Parametrised parallel-in/serial-out converter with valid/ready handshakes on both sides.
//   Takes one N-bit word (e.g. a packed polynomial or signature chunk) and emits it as N/M
//   beats of M bits. Supports MSB-first or LSB-first order, truncated length and abort.
//   Loads back-to-back with no bubble. Sits between packing stages and the M-bit output bus.
// PARAMETERS
//   N      1344               parallel input width in bits
//   M      64                 serial beat width in bits; N % M != 0 is an elaboration error
//   W      N/M (localparam)   maximum number of beats per word
//   CW     $clog2(W+1)        width of the length field (localparam)
// PORTS
//   clk           in   1    rising-edge clock
//   rst_n         in   1    asynchronous, active-low reset
//   in_valid      in   1    parallel word present
//   in_ready      out  1    block can accept a parallel word this cycle
//   in_data       in   N    parallel word
//   in_len        in   CW   beats to emit: 0 = W; values > W clamp to W
//   in_msb_first  in   1    1: first beat is in_data[N-1:N-M]; 0: first beat is in_data[M-1:0]
//   abort         in   1    synchronous: discard all remaining beats of the current word
//   out_valid     out  1    out_data holds a valid beat
//   out_ready     in   1    sink accepts the beat
//   out_data      out  M    current beat
//   out_last      out  1    current beat is the final beat of its word
//   busy          out  1    a word is loaded and not yet fully emitted
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; out_valid=0, out_last=0, busy=0, out_data=0.
//   in_ready=0 while rst_n=0; it becomes 1 on the first clk edge after release.
//   All inputs are ignored during reset.
//   Storage: N-bit shift register sreg, beat counter rem (CW bits), mode flag msb_q.
//   FSM IDLE:
//     - in_ready=1.
//     - On in_valid&&in_ready (load):
//         sreg<=in_data; msb_q<=in_msb_first; rem<=eff_len (0 or >W becomes W);
//         go to SHIFT.
//     - out_valid=1 from the next cycle, so latency is 1 cycle from load to the first beat.
//   FSM SHIFT:
//     - out_valid=1.
//     - out_data = msb_q ? sreg[N-1:N-M] : sreg[M-1:0].
//     - out_last = (rem==1).
//     - busy=1.
//     - When out_valid&&out_ready and rem>1:
//         sreg shifts by M toward the output slice (left if msb_q, else right),
//         zero-filled; rem<=rem-1.
//     - When out_valid&&out_ready and rem==1:
//         if in_valid, load the new word in the same cycle and stay in SHIFT
//         (zero bubble; in_ready=1 in this case only);
//         otherwise go to IDLE.
//     - in_ready = out_valid && out_ready && out_last (combinational). Otherwise in_ready=0.
//   Backpressure: while out_valid && !out_ready, out_data, out_last and rem hold stable.
//   out_data=0 whenever out_valid=0.
//   abort (any state):
//     - Next cycle, state is IDLE, out_valid=0, rem=0.
//     - abort has priority over a beat transfer and over a load in the same cycle.
//     - in_ready is forced to 0 in any cycle where abort=1.
//     - The sink may see a beat transferred in the abort cycle, but the block does not
//       advance and does not emit further beats.
//   Reset mid-word: all state clears immediately. No partial beat is emitted after release.
//   Beats per word = eff_len exactly. Beats beyond eff_len are never emitted.
//   The order within a beat is unchanged: bit M-1 of the beat is the higher-order bit.
// TESTING (N=256, M=64, W=4, in_data = {D3,D2,D1,D0}, Dk = 64'hk...k)
//   1. MSB-first, len=0, out_ready=1 -> D3,D2,D1,D0 on 4 consecutive cycles starting 1 cycle
//      after load; out_last only with D0; then IDLE, in_ready=1.
//   2. LSB-first, len=0 -> D0,D1,D2,D3; out_last with D3. len=2, MSB-first -> D3,D2;
//      out_last with D2. len=7 -> clamped to 4 beats.
//   3. Backpressure: out_ready=0 for 3 cycles at beat 2 -> D2 held with out_valid=1 for 4
//      cycles; no beat lost or duplicated.
//   4. Back-to-back: second word {E3..E0} valid during D0 transfer -> accepted in that cycle;
//      E3 appears the next cycle with no idle gap.
//   5. abort together with out_ready during D2 (in_valid=1) -> next cycle out_valid=0, IDLE,
//      no load; the following load works normally.
//   6. rst_n pulled low during beat D2 -> out_valid=0, out_data=0 asynchronously;
//      in_ready=0 while low, 1 one edge after release.

Source files
------------

// File: rtl/piso_stream_if.sv
// rtl/piso_stream_if.sv - Parallel-word input and serial-beat output handshake bundle for piso_stream.
interface piso_stream_if #(
    parameter int N = 1344,
    parameter int M = 64
);
    localparam int W  = N / M;
    localparam int CW = $clog2(W + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [CW-1:0] in_len;
    logic          in_msb_first;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  out_data;
    logic          out_last;
    logic          busy;

    modport slave (
        input  in_valid, in_data, in_len, in_msb_first, abort, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

    modport master (
        output in_valid, in_data, in_len, in_msb_first, abort, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - N-bit parallel word to M-bit beat serializer with zero-bubble reload and abort.
module piso_stream #(
    parameter int N = 1344,
    parameter int M = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    piso_stream_if.slave   bus
);
    localparam int W  = N / M;
    localparam int CW = $clog2(W + 1);

    generate
        if (N % M != 0) begin : g_bad_width
            $error("piso_stream: N must be a multiple of M");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_sreg, w_sreg_nxt;
    logic [CW-1:0] r_rem, w_rem_nxt;
    logic          r_msb, w_msb_nxt;
    // Holds in_ready low until the first edge after reset release.
    logic          r_alive;

    logic [CW-1:0] w_eff_len;
    logic          w_out_valid;
    logic          w_fire;
    logic          w_in_ready;
    logic          w_load;

    assign w_eff_len = ((bus.in_len == '0) || (bus.in_len > CW'(W))) ? CW'(W) : bus.in_len;

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_rem_nxt   = r_rem;
        w_msb_nxt   = r_msb;
        w_out_valid = (r_state == S_SHIFT);
        w_fire      = w_out_valid && bus.out_ready;
        w_in_ready  = 1'b0;
        if (!bus.abort) begin
            if (r_state == S_IDLE) w_in_ready = r_alive;
            else                   w_in_ready = w_fire && (r_rem == CW'(1));
        end
        w_load = bus.in_valid && w_in_ready;

        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = '0;
        end else if (w_load) begin
            w_state_nxt = S_SHIFT;
            w_sreg_nxt  = bus.in_data;
            w_msb_nxt   = bus.in_msb_first;
            w_rem_nxt   = w_eff_len;
        end else if (w_fire) begin
            w_rem_nxt = r_rem - CW'(1);
            if (r_rem > CW'(1)) w_sreg_nxt = r_msb ? (r_sreg << M) : (r_sreg >> M);
            else                w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_rem   <= '0;
            r_msb   <= 1'b0;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_rem   <= w_rem_nxt;
            r_msb   <= w_msb_nxt;
            r_alive <= 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_valid && (r_rem == CW'(1));
    assign bus.busy      = (r_state == S_SHIFT);
    assign bus.out_data  = !w_out_valid ? '0 : (r_msb ? r_sreg[N-1 -: M] : r_sreg[M-1:0]);
endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - Directed self-checking bench for piso_stream with N=256, M=64.
module tb_piso_stream;
    localparam int N = 256;
    localparam int M = 64;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [N-1:0] word_d;
    logic [N-1:0] word_e;

    piso_stream_if #(.N(N), .M(M)) bus ();

    piso_stream #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.in_len       = '0;
        bus.in_msb_first = 1'b0;
        bus.abort        = 1'b0;
        bus.out_ready    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus.in_valid = 1'b1;
        bus.in_data  = word_d;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.in_ready} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: got v/l/b/r=%b%b%b%b want 0000",
                     bus.out_valid, bus.out_last, bus.busy, bus.in_ready);
        end
        n_checks++;
        if (bus.out_data !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_data: got %h want 0", bus.out_data);
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL reset_first_edge: got ready/valid=%b%b want 10", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_order(input string name, input logic [N-1:0] word, input logic [2:0] len,
                              input logic msb, input int nbeats);
        logic [M-1:0] exp;
        @(negedge clk);
        drive_idle();
        bus.in_valid     = 1'b1;
        bus.in_data      = word;
        bus.in_len       = len;
        bus.in_msb_first = msb;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_load_ready: got %b want 1", name, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < nbeats; i++) begin
            #1;
            exp = msb ? word[N-1-M*i -: M] : word[M*i +: M];
            n_checks++;
            if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, (i == nbeats - 1), exp}) begin
                n_errors++;
                $display("FAIL %s_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", name, i,
                         bus.out_valid, bus.out_last, bus.out_data, (i == nbeats - 1), exp);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
            n_errors++;
            $display("FAIL %s_end_idle: got v/b/r=%b%b%b want 001", name,
                     bus.out_valid, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [M-1:0] exp_seq [4];
        exp_seq = '{word_d[255:192], word_d[191:128], word_d[127:64], word_d[63:0]};
        @(negedge clk);
        drive_idle();
        bus.in_valid = 1'b1; bus.in_data = word_d; bus.in_msb_first = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_data !== exp_seq[0]) begin
            n_errors++;
            $display("FAIL bp_beat0: got %h want %h", bus.out_data, exp_seq[0]);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.out_ready = 1'b1;
            #1;
            n_checks++;
            if ({bus.out_valid, bus.out_last, bus.out_data} !== {2'b10, exp_seq[1]}) begin
                n_errors++;
                $display("FAIL bp_hold%0d: got v=%b l=%b d=%h want v=1 l=0 d=%h", c,
                         bus.out_valid, bus.out_last, bus.out_data, exp_seq[1]);
            end
            @(negedge clk);
        end
        for (int i = 2; i < 4; i++) begin
            #1;
            n_checks++;
            if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, (i == 3), exp_seq[i]}) begin
                n_errors++;
                $display("FAIL bp_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", i,
                         bus.out_valid, bus.out_last, bus.out_data, (i == 3), exp_seq[i]);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_no_extra: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_idle();
        bus.in_valid = 1'b1; bus.in_data = word_d; bus.in_msb_first = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = word_e; bus.in_msb_first = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_last, bus.out_data} !== {2'b11, word_d[63:0]}) begin
            n_errors++;
            $display("FAIL b2b_handover: got r=%b l=%b d=%h want r=1 l=1 d=%h",
                     bus.in_ready, bus.out_last, bus.out_data, word_d[63:0]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, (i == 3), word_e[255-64*i -: 64]}) begin
                n_errors++;
                $display("FAIL b2b_e_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", i,
                         bus.out_valid, bus.out_last, bus.out_data, (i == 3), word_e[255-64*i -: 64]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        drive_idle();
        bus.in_valid = 1'b1; bus.in_data = word_d; bus.in_msb_first = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = word_e;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data} !== {2'b01, word_d[191:128]}) begin
            n_errors++;
            $display("FAIL abort_cycle: got r=%b v=%b d=%h want r=0 v=1 d=%h",
                     bus.in_ready, bus.out_valid, bus.out_data, word_d[191:128]);
        end
        @(negedge clk);
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready, bus.out_data} !== {3'b001, 64'h0}) begin
            n_errors++;
            $display("FAIL abort_after: got v=%b b=%b r=%b d=%h want v=0 b=0 r=1 d=0",
                     bus.out_valid, bus.busy, bus.in_ready, bus.out_data);
        end
        test_order("abort_reload", word_e, 3'd0, 1'b1, 4);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        drive_idle();
        bus.in_valid = 1'b1; bus.in_data = word_d; bus.in_msb_first = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.out_data !== word_d[191:128]) begin
            n_errors++;
            $display("FAIL mrst_pre: got %h want %h", bus.out_data, word_d[191:128]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.busy, bus.out_data} !== {3'b000, 64'h0}) begin
            n_errors++;
            $display("FAIL mrst_async: got v=%b r=%b b=%b d=%h want all 0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL mrst_release: got r=%b v=%b want 00", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL mrst_after_edge: got r=%b v=%b want 10", bus.in_ready, bus.out_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        word_d = {64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111, 64'h0000000000000000};
        word_e = {64'hEEEE3333EEEE3333, 64'hEEEE2222EEEE2222, 64'hEEEE1111EEEE1111, 64'hEEEE0000EEEE0000};
        test_reset();
        test_order("msb_len0", word_d, 3'd0, 1'b1, 4);
        test_order("lsb_len0", word_d, 3'd0, 1'b0, 4);
        test_order("msb_len2", word_d, 3'd2, 1'b1, 2);
        test_order("msb_len7", word_d, 3'd7, 1'b1, 4);
        test_order("lsb_len1", word_e, 3'd1, 1'b0, 1);
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
